// File: rtl/ram512_loader_pkg.sv
// Shared types and constants for the ram512 bulk loader.
package ram512_loader_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW    = 9;
  localparam int DEF_CW    = 10;
  localparam int DEPTH     = 512;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ram512_loader_if.sv
// Stream handshake plus ram512 port bundle; master is the loader side.
interface ram512_loader_if
  import ram512_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] ram_in;
  logic [AW-1:0]    ram_address;
  logic             ram_load;
  logic [WIDTH-1:0] ram_out;

  modport master (
    input  s_data, s_valid, ram_out,
    output s_ready, ram_in, ram_address, ram_load
  );

  modport slave (
    output s_data, s_valid, ram_out,
    input  s_ready, ram_in, ram_address, ram_load
  );

endinterface

// File: rtl/ram512.sv
// 512 x 16 RAM: synchronous write on load, combinational read of address.
module ram512 (
  input  logic        clk,
  input  logic [15:0] in,
  input  logic [8:0]  address,
  input  logic        load,
  output logic [15:0] out
);

  logic [15:0] mem_r [0:511];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (load) begin
      mem_r[address] <= in;
    end
  end

  assign out = mem_r[address];

endmodule

// File: rtl/ram512_loader_sum.sv
// Clearable wrap-around accumulator used for the load and verify checksums.
module ram512_loader_sum
  import ram512_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_r;

  // Accumulator register; clear takes priority over add
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_r <= '0;
    end else if (clr) begin
      sum_r <= '0;
    end else if (en) begin
      sum_r <= sum_r + d;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/ram512_loader.sv
// Bulk stream-to-RAM loader for ram512. The read-back checksum verify pass
// is built only when RAM512_LOADER_VERIFY_EN is defined.
module ram512_loader
  import ram512_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CW-1:0]    count,
  ram512_loader_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] checksum
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(DEPTH);

  state_t           state_r, state_s;
  logic [AW-1:0]    base_r;
  logic [CW-1:0]    idx_r;
  logic [CW-1:0]    cnt_r;
  logic             s_ready_r, busy_r, done_r, error_r;
  logic             hs_s, last_s, start_ok_s, csum_clr_s;
  logic [WIDTH-1:0] csum_s;

  assign hs_s       = bus.s_valid & s_ready_r;
  assign last_s     = (idx_r + CW'(1)) == cnt_r;
  assign start_ok_s = start && (count != '0) && (count <= MAX_COUNT);
  assign csum_clr_s = (state_r == ST_IDLE) && start_ok_s;

  ram512_loader_sum #(.WIDTH(WIDTH)) u_csum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (csum_clr_s),
    .en      (hs_s),
    .d       (bus.s_data),
    .sum     (csum_s)
  );

`ifdef RAM512_LOADER_VERIFY_EN
  logic [WIDTH-1:0] vsum_s, vsum_next_s;

  ram512_loader_sum #(.WIDTH(WIDTH)) u_vsum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (csum_clr_s),
    .en      (state_r == ST_VERIFY),
    .d       (bus.ram_out),
    .sum     (vsum_s)
  );

  // Final verify word is folded in combinationally so the compare lands on the last read
  assign vsum_next_s = vsum_s + bus.ram_out;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !start_ok_s) begin
          state_s = ST_FINISH;
        end else if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (hs_s && last_s) begin
`ifdef RAM512_LOADER_VERIFY_EN
          state_s = ST_VERIFY;
`else
          state_s = ST_FINISH;
`endif
        end else begin
          state_s = ST_LOAD;
        end
      end
`ifdef RAM512_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (last_s) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_VERIFY;
        end
      end
`endif
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Operation registers: latched request, word index, status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r    <= '0;
      idx_r     <= '0;
      cnt_r     <= '0;
      error_r   <= 1'b0;
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      s_ready_r <= (state_s == ST_LOAD);
      busy_r    <= (state_s == ST_LOAD) || (state_s == ST_VERIFY);
      done_r    <= (state_s == ST_FINISH);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            error_r <= (count > MAX_COUNT);
            if (start_ok_s) begin
              base_r <= base_addr;
              cnt_r  <= count;
              idx_r  <= '0;
            end
          end
        end
        ST_LOAD: begin
          // Index restarts at zero so the verify pass walks the same region
          if (hs_s) begin
            idx_r <= last_s ? '0 : idx_r + CW'(1);
          end
        end
`ifdef RAM512_LOADER_VERIFY_EN
        ST_VERIFY: begin
          idx_r <= idx_r + CW'(1);
          if (last_s) begin
            error_r <= (vsum_next_s != csum_s);
          end
        end
`endif
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign bus.s_ready     = s_ready_r;
  assign bus.ram_load    = hs_s;
  assign bus.ram_in      = s_ready_r ? bus.s_data : '0;
  assign bus.ram_address = base_r + idx_r[AW-1:0];
  assign busy            = busy_r;
  assign done            = done_r;
  assign error           = error_r;
  assign checksum        = csum_s;

endmodule
